// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    // Bit counter width: enough to count 0..width.
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/serial_adder_fa_cell.sv
// Single-bit full-adder cell; the only arithmetic element of the serial adder.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ c;
    assign co = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one sum bit per clock, LSB first, through a single fa_cell.
// Defining SERIAL_ADDER_SUB_EN adds the sub port for a - b via operand inversion.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int unsigned     CntW    = cnt_width(WIDTH);
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q, sum_q;
    logic [CntW-1:0]  cnt_q;
    logic             c_q, c_msb_in_q, cout_q;
    logic             load, last;
    logic [WIDTH-1:0] b_load;
    logic             c_load;
    logic             s, co;

`ifdef SERIAL_ADDER_SUB_EN
    // Two's complement subtraction: a + ~b + 1.
    assign b_load = sub ? ~b : b;
    assign c_load = sub ? 1'b1 : cin;
`else
    assign b_load = b;
    assign c_load = cin;
`endif

    fa_cell u_fa (
        .a  (a_q[0]),
        .b  (b_q[0]),
        .c  (c_q),
        .s  (s),
        .co (co)
    );

    assign last = (cnt_q == LastCnt);
    assign load = start && (state_q == StIdle || state_q == StDone);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StRun;
            StRun:   if (last) state_d = StDone;
            StDone:  state_d = start ? StRun : StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        unique case (state_q)
            StRun:   busy = 1'b1;
            StDone:  done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q        <= '0;
            b_q        <= '0;
            sum_q      <= '0;
            cnt_q      <= '0;
            c_q        <= 1'b0;
            c_msb_in_q <= 1'b0;
            cout_q     <= 1'b0;
        end else if (load) begin
            a_q   <= a;
            b_q   <= b_load;
            c_q   <= c_load;
            cnt_q <= '0;
        end else if (state_q == StRun) begin
            a_q   <= a_q >> 1;
            b_q   <= b_q >> 1;
            sum_q <= {s, sum_q[WIDTH-1:1]};
            c_q   <= co;
            cnt_q <= cnt_q + CntW'(1);
            // Result flags only change on the final step so they hold between operations.
            if (last) begin
                c_msb_in_q <= c_q;
                cout_q     <= co;
            end
        end
    end

    assign sum      = sum_q;
    assign cout     = cout_q;
    assign overflow = c_msb_in_q ^ cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8) with a result scoreboard.
module tb_serial_adder;

    localparam int unsigned W = 8;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    logic         clk, rst_n, start, cin;
    logic [W-1:0] a, b;
    logic         busy, done, cout, overflow;
    logic [W-1:0] sum;
`ifdef SERIAL_ADDER_SUB_EN
    logic         sub;
`endif

    int   total = 0;
    int   bad   = 0;
    exp_t q[$];

    serial_adder #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a        (a),
        .b        (b),
        .cin      (cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub      (sub),
`endif
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .cout     (cout),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Scoreboard: every done pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            exp_t e;
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_done: done=1 with no pending operation");
            end else begin
                e = q.pop_front();
                if ({sum, cout, overflow, busy} !== {e.sum, e.cout, e.ovf, 1'b0}) begin
                    bad++;
                    $display("FAIL result: got sum=%h cout=%b ovf=%b busy=%b want sum=%h cout=%b ovf=%b busy=0",
                             sum, cout, overflow, busy, e.sum, e.cout, e.ovf);
                end
            end
        end
    end

    task automatic push_exp(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                            input logic tc, input logic tsub);
        logic [W-1:0] beff;
        logic         ceff;
        logic [W:0]   full;
        exp_t         e;
        beff   = tsub ? ~tb_ : tb_;
        ceff   = tsub ? 1'b1 : tc;
        full   = {1'b0, ta} + {1'b0, beff} + {{W{1'b0}}, ceff};
        e.sum  = full[W-1:0];
        e.cout = full[W];
        e.ovf  = (ta[W-1] == beff[W-1]) && (full[W-1] != ta[W-1]);
        q.push_back(e);
    endtask

    task automatic set_inputs(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                              input logic tc, input logic tsub);
        a   = ta;
        b   = tb_;
        cin = tc;
`ifdef SERIAL_ADDER_SUB_EN
        sub = tsub;
`endif
        start = 1'b1;
        push_exp(ta, tb_, tc, tsub);
    endtask

    // Drives one start pulse; returns at the falling edge after the accepting edge E0.
    task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                            input logic tc, input logic tsub);
        @(negedge clk);
        set_inputs(ta, tb_, tc, tsub);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts rising edges until done is seen; n=40 means it never came.
    task automatic wait_done(output int n);
        n = 0;
        while (n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (done) break;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        start = 1'b0;
        a = '0; b = '0; cin = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
        sub = 1'b0;
`endif
        repeat (3) @(negedge clk);
        total++;
        if ({busy, done, sum, cout, overflow} !== '0) begin
            bad++;
            $display("FAIL reset_values: got busy=%b done=%b sum=%h cout=%b ovf=%b want all 0",
                     busy, done, sum, cout, overflow);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic;
        int n;
        start_op(8'h0F, 8'h01, 1'b0, 1'b0);
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL busy_after_start: got %b want 1", busy);
        end
        wait_done(n);
        total++;
        if (n != 8) begin
            bad++;
            $display("FAIL latency: got %0d edges want 8", n);
        end
        @(negedge clk);
        total++;
        if (done !== 1'b0 || sum !== 8'h10) begin
            bad++;
            $display("FAIL done_width_hold: got done=%b sum=%h want done=0 sum=10", done, sum);
        end
    endtask

    task automatic test_carry_overflow;
        int n;
        start_op(8'hFF, 8'h01, 1'b0, 1'b0);
        wait_done(n);
        start_op(8'h7F, 8'h01, 1'b0, 1'b0);
        wait_done(n);
        total++;
        if (n != 8) begin
            bad++;
            $display("FAIL latency_ovf: got %0d edges want 8", n);
        end
    endtask

    task automatic test_start_ignored;
        int pulses;
        @(negedge clk);
        set_inputs(8'h00, 8'h00, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL busy_mid_run: got %b want 1", busy);
        end
        repeat (4) @(negedge clk);
        start = 1'b0;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        total++;
        if (pulses != 1) begin
            bad++;
            $display("FAIL start_ignored: got %0d done pulses want 1", pulses);
        end
    endtask

    task automatic test_back_to_back;
        int n1, n2;
        start_op(8'h10, 8'h20, 1'b0, 1'b0);
        wait_done(n1);
        set_inputs(8'h03, 8'h04, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        wait_done(n2);
        total++;
        if (n1 + 1 + n2 != 17) begin
            bad++;
            $display("FAIL back_to_back: got second done at E%0d want E17", n1 + 1 + n2);
        end
        total++;
        if (sum !== 8'h07) begin
            bad++;
            $display("FAIL back_to_back_sum: got %h want 07", sum);
        end
    endtask

    task automatic test_reset_mid_run;
        int pulses, n;
        start_op(8'h55, 8'h22, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        total++;
        if ({busy, done, sum, cout, overflow} !== '0) begin
            bad++;
            $display("FAIL reset_mid_run: got busy=%b done=%b sum=%h cout=%b ovf=%b want all 0",
                     busy, done, sum, cout, overflow);
        end
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        total++;
        if (pulses != 0) begin
            bad++;
            $display("FAIL aborted_done: got %0d done pulses want 0", pulses);
        end
        start_op(8'h12, 8'h34, 1'b1, 1'b0);
        wait_done(n);
        total++;
        if (n != 8 || sum !== 8'h47) begin
            bad++;
            $display("FAIL after_reset: got %0d edges sum=%h want 8 edges sum=47", n, sum);
        end
    endtask

`ifdef SERIAL_ADDER_SUB_EN
    task automatic test_sub;
        int n;
        start_op(8'h05, 8'h07, 1'b0, 1'b1);
        wait_done(n);
        total++;
        if (sum !== 8'hFE || cout !== 1'b0) begin
            bad++;
            $display("FAIL sub_borrow: got sum=%h cout=%b want FE 0", sum, cout);
        end
        start_op(8'h80, 8'h01, 1'b1, 1'b1);
        wait_done(n);
        total++;
        if (sum !== 8'h7F || overflow !== 1'b1) begin
            bad++;
            $display("FAIL sub_overflow: got sum=%h ovf=%b want 7F 1", sum, overflow);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_carry_overflow();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid_run();
`ifdef SERIAL_ADDER_SUB_EN
        test_sub();
`endif
        repeat (3) @(negedge clk);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending results want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
